s_mem_stream_reader: RTL and testbench
======================================

Name: s_mem_stream_reader

Overview:
- Reader counterpart to the S-memory index populator.
- On `start`, reads a contiguous range of S memory, one byte at a time, through the single-port on-chip RAM read path. It compensates for a fixed RAM read latency.
- Presents each byte on a valid/ready output stream, tagged with its address.
- Used by the RC4 datapath and the debug/verification path to dump or consume the permuted S array.

Parameters:
- ADDR_W, 8, S-memory address width.
- DATA_W, 8, S-memory data width.
- READ_LATENCY, 1, cycles from `mem_address` stable to `mem_rdata` valid; legal values 1..3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level-sampled; launches a read sweep when in IDLE or DONE
- base_addr  in  ADDR_W  first address; sampled when start accepted
- length  in  ADDR_W+1  byte count 0..256; sampled when start accepted
- mem_address  out  ADDR_W  S-memory address
- mem_wren  out  1  S-memory write enable; constant 0
- mem_rdata  in  DATA_W  S-memory read data
- out_data  out  DATA_W  streamed byte
- out_addr  out  ADDR_W  address of out_data
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  consumer accepts byte
- busy  out  1  sweep in progress
- done  out  1  sweep complete; held until next start or reset
- mismatch  out  1  identity-check failure flag (see Optional Feature)
- mismatch_addr  out  ADDR_W  first failing address

Behaviour:
- Reset values:
  - mem_address=0, mem_wren=0
  - out_data=0, out_addr=0, out_valid=0
  - busy=0, done=0
  - mismatch=0, mismatch_addr=0
  - state IDLE, internal counters 0
- Registered state; all outputs registered.
- States and transitions:
  - IDLE: wait for start; on start, latch base_addr and length.
    - length > 256 clamps to 256.
    - length==0 goes directly to DONE next cycle; no reads, no out_valid.
    - Otherwise go to ISSUE.
  - ISSUE: drive mem_address = (base + offset) mod 2^ADDR_W. Wrap-around is required: base 0xFE, length 4 reads FE, FF, 00, 01. Load latency counter; go to WAIT.
  - WAIT: count READ_LATENCY cycles with mem_address held stable. Then capture mem_rdata into out_data, set out_addr to the current address, assert out_valid, and go to PRESENT.
  - PRESENT: hold out_data, out_addr and out_valid stable until out_valid && out_ready.
    - On handshake: out_valid drops next cycle and offset increments.
    - If offset+1 == length, go to DONE; else go to ISSUE.
  - DONE: done=1, busy=0. start relaunches the sweep with newly sampled base_addr/length (done clears the same cycle the sweep starts).
- busy=1 in ISSUE, WAIT and PRESENT.
- Throughput: one byte per READ_LATENCY+2 cycles with out_ready tied high.
- start asserted while busy is ignored.
- out_ready low indefinitely: stall in PRESENT, no further memory reads.
- reset mid-sweep: return to IDLE on the next edge, all outputs to reset values, no partial done.
- Offset counter width ADDR_W+1, so length 256 terminates correctly.

Optional Feature:
- Macro S_MEM_IDENTITY_CHECK_EN.
- Defined:
  - Each captured byte is compared against its address (checks the s[i]=i initialisation).
  - On the first inequality in a sweep, mismatch is set to 1 and mismatch_addr latches that address.
  - Both hold until the next accepted start or reset.
  - Comparison is done at capture time and adds no latency.
- Undefined: mismatch and mismatch_addr are tied to 0; no comparator logic.

Decomposition:
- Shared package s_mem_pkg:
  - S_ADDR_W=8, S_DATA_W=8, S_MEM_DEPTH=256
  - reader state enum type s_rd_state_t: IDLE, ISSUE, WAIT, PRESENT, DONE
- One natural sub-module: s_mem_read_latency_ctr, a loadable down-counter producing the WAIT exit strobe; reusable by other S-memory readers (RC4 swap/keystream FSMs).
- Remainder stays flat.

Test Plan:
- Memory preloaded s[i]=i; start, base 0, length 256, out_ready=1:
  - 256 bytes, out_data==out_addr==0..255 in order.
  - done rises after the last handshake and stays 1.
  - mismatch=0 (macro on).
- base 0xFE, length 4: out_addr sequence FE, FF, 00, 01; data matches memory contents.
- length 0: done=1 two cycles after start; out_valid never asserts; mem_address unchanged.
- Backpressure during a length-3 sweep: drop out_ready for 10 cycles while out_valid=1.
  - out_data/out_addr stable throughout.
  - No new mem_address change.
  - Sweep resumes; exactly 3 handshakes.
- Macro on, s[0x10]=0x55, s[0x20]=0x00, full sweep: mismatch=1, mismatch_addr=0x10 (first failure retained).
- reset asserted in the middle of WAIT: next cycle all outputs at reset values. A subsequent start, base 5, length 1 yields a single byte at out_addr=5, then done.

Source files
------------

// File: rtl/s_mem_pkg.sv
// rtl/s_mem_pkg.sv - shared S-memory widths and reader state encoding
package s_mem_pkg;

    localparam int S_ADDR_W    = 8;
    localparam int S_DATA_W    = 8;
    localparam int S_MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } s_rd_state_t;

endpackage

// File: rtl/s_mem_read_latency_ctr.sv
// rtl/s_mem_read_latency_ctr.sv - loadable down-counter marking the end of a RAM read wait
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   load_i      reload the counter with LATENCY-1 (asserted in the cycle before the wait)
//   expired_o   high while the counter is at zero, i.e. in the last wait cycle
module s_mem_read_latency_ctr #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LATENCY - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/s_mem_stream_reader.sv
// rtl/s_mem_stream_reader.sv - sweeps a range of S memory and streams each byte with its address
//
// Optional feature macro: S_MEM_IDENTITY_CHECK_EN (flags the first byte whose value differs from its address)
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   start, base_addr, length      launch a sweep of length bytes from base_addr (IDLE/DONE only)
//   mem_address, mem_wren, mem_rdata   single-port RAM read path (never writes)
//   out_data, out_addr, out_valid, out_ready   byte stream to the consumer
//   busy, done                    sweep status
//   mismatch, mismatch_addr       identity-check result
module s_mem_stream_reader
    import s_mem_pkg::*;
#(
    parameter int ADDR_W       = S_ADDR_W,
    parameter int DATA_W       = S_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [ADDR_W-1:0] mismatch_addr
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    s_rd_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   off_q, off_d;
    logic [ADDR_W:0]   off_next;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_ok;
    logic              capture;
    logic              lat_load;
    logic              lat_expired;

    s_mem_read_latency_ctr #(
        .LATENCY (READ_LATENCY),
        .CNT_W   (2)
    ) u_lat_ctr (
        .clk       (clk),
        .reset     (reset),
        .load_i    (lat_load),
        .expired_o (lat_expired)
    );

    assign start_ok    = start && (state_q == IDLE || state_q == DONE);
    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign off_next    = off_q + (ADDR_W+1)'(1);
    assign capture     = (state_q == WAIT) && lat_expired;
    assign lat_load    = (state_q == ISSUE);

    // The address register is loaded on the edge that enters ISSUE, so the RAM
    // already sees a stable address during ISSUE and the data arrives by the
    // end of the READ_LATENCY wait cycles.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        off_d         = off_q;
        mem_address_d = mem_address_q;
        out_data_d    = out_data_q;
        out_addr_d    = out_addr_q;
        out_valid_d   = out_valid_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    base_d = base_addr;
                    len_d  = len_clamped;
                    off_d  = '0;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d       = ISSUE;
                        mem_address_d = base_addr;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (capture) begin
                    out_data_d  = mem_rdata;
                    out_addr_d  = mem_address_q;
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    off_d       = off_next;
                    if (off_next == len_q) begin
                        state_d = DONE;
                    end else begin
                        state_d       = ISSUE;
                        mem_address_d = base_q + off_next[ADDR_W-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == ISSUE) || (state_d == WAIT) || (state_d == PRESENT);
        done_d = (state_q == DONE) && !start_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            base_q        <= '0;
            len_q         <= '0;
            off_q         <= '0;
            mem_address_q <= '0;
            out_data_q    <= '0;
            out_addr_q    <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            off_q         <= off_d;
            mem_address_q <= mem_address_d;
            out_data_q    <= out_data_d;
            out_addr_q    <= out_addr_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

`ifdef S_MEM_IDENTITY_CHECK_EN
    logic              mm_q;
    logic [ADDR_W-1:0] mma_q;

    // Only the first failing address of a sweep is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            mm_q  <= 1'b0;
            mma_q <= '0;
        end else if (start_ok) begin
            mm_q  <= 1'b0;
            mma_q <= '0;
        end else if (capture && !mm_q && (mem_rdata != DATA_W'(mem_address_q))) begin
            mm_q  <= 1'b1;
            mma_q <= mem_address_q;
        end
    end

    assign mismatch      = mm_q;
    assign mismatch_addr = mma_q;
`else
    assign mismatch      = 1'b0;
    assign mismatch_addr = '0;
`endif

    assign mem_address = mem_address_q;
    assign mem_wren    = 1'b0;
    assign out_data    = out_data_q;
    assign out_addr    = out_addr_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_s_mem_stream_reader.sv
// tb/tb_s_mem_stream_reader.sv - scoreboard bench for s_mem_stream_reader
module tb_s_mem_stream_reader;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic [7:0] mem_address;
    logic       mem_wren;
    logic [7:0] mem_rdata;
    logic [7:0] out_data;
    logic [7:0] out_addr;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic [7:0] mismatch_addr;

    logic [7:0] mem [256];
    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         hs_cnt = 0;

    always #5 clk = ~clk;

    s_mem_stream_reader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .mem_address   (mem_address),
        .mem_wren      (mem_wren),
        .mem_rdata     (mem_rdata),
        .out_data      (out_data),
        .out_addr      (out_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .mismatch      (mismatch),
        .mismatch_addr (mismatch_addr)
    );

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk) mem_rdata <= mem[mem_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change on negedge, so sampling 1 time unit later sees
    // the values that the next posedge will act on.
    always begin
        @(negedge clk);
        #1;
        if (!reset && out_valid && out_ready) begin
            hs_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got addr %0h data %0h expected none", out_addr, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_addr !== e.addr || out_data !== e.data) begin
                    bad++;
                    $display("FAIL stream_byte: got addr %0h data %0h expected addr %0h data %0h",
                             out_addr, out_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr = b + 8'(i);
            e.data = mem[e.addr];
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input logic [7:0] b, input logic [8:0] l);
        @(negedge clk);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got done=%0b expected 1", name, done);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got out_valid=%0b expected 1", name, out_valid);
        end
    endtask

    initial begin
        int         hs0;
        logic [7:0] ma0;
        logic [7:0] d0, a0, m0;
        bit         seen_valid;
        bit         stable;
        logic       exp_mm;

        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        repeat (3) @(negedge clk);

        chk("reset_mem_address", 32'(mem_address), 0);
        chk("reset_mem_wren", 32'(mem_wren), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_mismatch", 32'(mismatch), 0);
        reset = 1'b0;

        // Full identity sweep.
        hs0 = hs_cnt;
        push_exp(8'h00, 256);
        pulse_start(8'h00, 9'd256);
        chk("full_busy", 32'(busy), 1);
        wait_done("full", 2000);
        chk("full_handshakes", 32'(hs_cnt - hs0), 256);
        chk("full_queue_empty", 32'(exp_q.size()), 0);
        repeat (5) @(negedge clk);
        chk("full_done_held", 32'(done), 1);
        chk("full_busy_low", 32'(busy), 0);
        chk("full_mismatch", 32'(mismatch), 0);

        // Wrap-around sweep.
        hs0 = hs_cnt;
        push_exp(8'hFE, 4);
        pulse_start(8'hFE, 9'd4);
        chk("wrap_done_cleared", 32'(done), 0);
        wait_done("wrap", 200);
        chk("wrap_handshakes", 32'(hs_cnt - hs0), 4);
        chk("wrap_queue_empty", 32'(exp_q.size()), 0);

        // Zero length: done two cycles after start, no reads, no bytes.
        ma0 = mem_address;
        hs0 = hs_cnt;
        seen_valid = 1'b0;
        pulse_start(8'h40, 9'd0);
        chk("len0_done_after1", 32'(done), 0);
        @(negedge clk);
        chk("len0_done_after2", 32'(done), 1);
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("len0_no_valid", 32'(seen_valid), 0);
        chk("len0_mem_address", 32'(mem_address), 32'(ma0));
        chk("len0_handshakes", 32'(hs_cnt - hs0), 0);

        // Backpressure on a 3-byte sweep.
        hs0 = hs_cnt;
        out_ready = 1'b0;
        push_exp(8'h30, 3);
        pulse_start(8'h30, 9'd3);
        wait_valid("bp", 50);
        d0 = out_data; a0 = out_addr; m0 = mem_address;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_data !== d0 || out_addr !== a0 || mem_address !== m0 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 1);
        chk("bp_addr", 32'(a0), 32'h30);
        out_ready = 1'b1;
        wait_done("bp", 200);
        chk("bp_handshakes", 32'(hs_cnt - hs0), 3);
        chk("bp_queue_empty", 32'(exp_q.size()), 0);

        // Corrupted identity: first failure at 0x10 is kept.
        mem[8'h10] = 8'h55;
        mem[8'h20] = 8'h00;
`ifdef S_MEM_IDENTITY_CHECK_EN
        exp_mm = 1'b1;
`else
        exp_mm = 1'b0;
`endif
        push_exp(8'h00, 256);
        pulse_start(8'h00, 9'd256);
        wait_done("corrupt", 2000);
        chk("corrupt_mismatch", 32'(mismatch), 32'(exp_mm));
        chk("corrupt_mismatch_addr", 32'(mismatch_addr), exp_mm ? 32'h10 : 32'h0);
        chk("corrupt_queue_empty", 32'(exp_q.size()), 0);
        mem[8'h10] = 8'h10;
        mem[8'h20] = 8'h20;

        // Reset while waiting on the RAM: start accepted, ISSUE, then WAIT.
        pulse_start(8'h07, 9'd2);
        chk("rst_busy_before", 32'(busy), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mem_address", 32'(mem_address), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_addr", 32'(out_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        chk("rst_mismatch_addr", 32'(mismatch_addr), 0);
        reset = 1'b0;
        hs0 = hs_cnt;
        push_exp(8'h05, 1);
        pulse_start(8'h05, 9'd1);
        wait_done("post_rst", 100);
        chk("post_rst_handshakes", 32'(hs_cnt - hs0), 1);
        chk("post_rst_queue_empty", 32'(exp_q.size()), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
